// File: rtl/fft_iter_pkg.sv
// Shared definitions for the iterative FFT: frame scheduler state encoding
// and the bit-reverse helper used by the scheduler and the address generator.
package fft_iter_pkg;

    typedef enum logic [2:0] {
        SCHED_IDLE    = 3'd0,
        SCHED_LOAD    = 3'd1,
        SCHED_KICK    = 3'd2,
        SCHED_COMPUTE = 3'd3,
        SCHED_UNLOAD  = 3'd4
    } sched_state_t;

    localparam int BITREV_MAX_WL = 16;
    localparam int BITREV_IW     = $clog2(BITREV_MAX_WL);

    // Reverses the low 'width' bits of v; bits at and above 'width' return as zero.
    function automatic logic [BITREV_MAX_WL-1:0] bit_reverse(
        input logic [BITREV_MAX_WL-1:0] v,
        input int                       width
    );
        logic [BITREV_MAX_WL-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX_WL; i++) begin
            if (i < width) begin
                r[BITREV_IW'(i)] = v[BITREV_IW'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sched_stream_cnt.sv
// Sample position counter for one frame phase; NWL+1 bits wide so a full count
// of N is representable, with a flag marking position N-1.
module fft_sched_stream_cnt #(
    parameter int NWL = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    output logic [NWL:0] count,
    output logic         at_last
);

    localparam logic [NWL:0] LAST = {1'b0, {NWL{1'b1}}};
    localparam logic [NWL:0] ONE  = (NWL+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            if (clr) begin
                count <= '0;
            end else if (inc) begin
                count <= count + ONE;
            end
        end
    end

    assign at_last = (count == LAST);

endmodule

// File: rtl/fft_iter_frame_scheduler.sv
// Frame sequencer for the iterative radix-2 FFT: load N samples, run the butterfly engine, unload N results.
// Define FFT_SCHED_BITREV_EN to read results at bit-reversed addresses (natural frequency order out).
module fft_iter_frame_scheduler
    import fft_iter_pkg::*;
#(
    parameter int NWL     = 5,
    parameter int FCNT_WL = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               mem_wr_en,
    output logic [NWL-1:0]     mem_wr_addr,
    output logic               mem_rd_en,
    output logic [NWL-1:0]     mem_rd_addr,
    output logic               mem_sel,
    output logic               core_start,
    input  logic               core_done,
    output logic               busy,
    output logic [FCNT_WL-1:0] frame_cnt
);

    localparam logic [FCNT_WL-1:0] FCNT_ONE = FCNT_WL'(1);

    sched_state_t state, state_next;

    logic [NWL:0] wr_cnt;
    logic [NWL:0] rd_cnt;
    logic         wr_at_last;
    logic         rd_at_last;
    logic         cnt_clr;
    logic         rd_window;
    logic         last_issued;
    logic         out_fire;
    logic         last_fire;

    fft_sched_stream_cnt #(.NWL(NWL)) u_wr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (cnt_clr),
        .inc     (mem_wr_en),
        .count   (wr_cnt),
        .at_last (wr_at_last)
    );

    fft_sched_stream_cnt #(.NWL(NWL)) u_rd_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (cnt_clr),
        .inc     (mem_rd_en),
        .count   (rd_cnt),
        .at_last (rd_at_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCHED_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        in_ready   = 1'b0;
        mem_sel    = 1'b0;
        core_start = 1'b0;
        rd_window  = 1'b0;
        busy       = (state != SCHED_IDLE);
        case (state)
            SCHED_IDLE: begin
                cnt_clr    = 1'b1;
                state_next = SCHED_LOAD;
            end
            SCHED_LOAD: begin
                in_ready = en & ~wr_cnt[NWL];
                if (in_valid && in_ready && wr_at_last) begin
                    state_next = SCHED_KICK;
                end
            end
            SCHED_KICK: begin
                mem_sel    = 1'b1;
                core_start = 1'b1;
                state_next = SCHED_COMPUTE;
            end
            SCHED_COMPUTE: begin
                mem_sel = 1'b1;
                if (core_done) begin
                    state_next = SCHED_UNLOAD;
                end
            end
            SCHED_UNLOAD: begin
                rd_window = 1'b1;
                if (last_fire) begin
                    state_next = SCHED_IDLE;
                end
            end
            default: state_next = SCHED_IDLE;
        endcase
        if (!en) begin
            state_next = state;
        end
    end

    assign mem_wr_en   = in_valid & in_ready;
    assign mem_wr_addr = wr_cnt[NWL-1:0];

    // At most one read is ever outstanding: a new read issues only when the
    // output register is empty or being drained this cycle.
    assign mem_rd_en = en & rd_window & ~rd_cnt[NWL] & (~out_valid | out_ready);
    assign out_fire  = en & out_valid & out_ready;
    assign out_last  = out_valid & last_issued;
    assign last_fire = out_fire & out_last;

`ifdef FFT_SCHED_BITREV_EN
    logic [BITREV_MAX_WL-1:0] rd_rev;
    assign rd_rev      = bit_reverse(BITREV_MAX_WL'(rd_cnt[NWL-1:0]), NWL);
    assign mem_rd_addr = rd_rev[NWL-1:0];
`else
    assign mem_rd_addr = rd_cnt[NWL-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            last_issued <= 1'b0;
            frame_cnt   <= '0;
        end else if (en) begin
            if (mem_rd_en) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (cnt_clr) begin
                last_issued <= 1'b0;
            end else if (mem_rd_en && rd_at_last) begin
                last_issued <= 1'b1;
            end
            if (last_fire) begin
                frame_cnt <= frame_cnt + FCNT_ONE;
            end
        end
    end

endmodule
